count_display_driver: RTL and testbench

COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

---
 rtl/count_display_if.sv | 22 ++
 rtl/count_display_driver.sv | 147 ++++++++++++++
 tb/tb_count_display_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/count_display_if.sv
// Bundle of the counter-sample inputs and the two-digit display / wrap-flag outputs
// that sit between the upstream counter and count_display_driver.
interface count_display_if;
    logic [3:0] count_in;
    logic       count_valid;
    logic       wrap_ack;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       wrap_up;
    logic       wrap_dn;

    modport master (
        output count_in, count_valid, wrap_ack,
        input  an, seg, dp, wrap_up, wrap_dn
    );

    modport slave (
        input  count_in, count_valid, wrap_ack,
        output an, seg, dp, wrap_up, wrap_dn
    );
endinterface

// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..15 counter, with sticky
// up/down wrap detection shown on the ones-digit decimal point.
module count_display_driver #(
    parameter int REFRESH_CNT = 50000
) (
    input  logic            clk,
    input  logic            clr,
    count_display_if.slave  bus
);

    localparam logic [15:0] RC_LAST = 16'(REFRESH_CNT - 1);
    localparam logic [0:0]  ST_ONES = 1'b0;
    localparam logic [0:0]  ST_TENS = 1'b1;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Active-low a..g pattern for a decimal digit; anything else shows blank.
    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'b0000001;
            4'd1:    font = 7'b1001111;
            4'd2:    font = 7'b0010010;
            4'd3:    font = 7'b0000110;
            4'd4:    font = 7'b1001100;
            4'd5:    font = 7'b0100100;
            4'd6:    font = 7'b0100000;
            4'd7:    font = 7'b0001111;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0000100;
            default: font = SEG_BLANK;
        endcase
    endfunction

    // Declaration initialisers make the power-up state equal the reset state.
    logic [3:0]  cur_r     = 4'd0;
    logic        primed_r  = 1'b0;
    logic        wrap_up_r = 1'b0;
    logic        wrap_dn_r = 1'b0;
    logic [15:0] rc_r      = 16'd0;
    logic [0:0]  state_r   = ST_ONES;
    logic [1:0]  an_r      = 2'b11;
    logic [6:0]  seg_r     = SEG_BLANK;
    logic        dp_r      = 1'b1;

    logic        tens_s;
    logic [3:0]  ones_s;
    logic        up_evt_s;
    logic        dn_evt_s;
    logic [15:0] rc_nx_s;
    logic [0:0]  state_nx_s;
    logic [1:0]  an_nx_s;
    logic [6:0]  seg_nx_s;
    logic        dp_nx_s;

    // Digit split, wrap detection, scan sequencing and next display outputs.
    always_comb begin
        tens_s     = 1'b0;
        ones_s     = cur_r;
        rc_nx_s    = 16'd0;
        state_nx_s = state_r;
        an_nx_s    = 2'b11;
        seg_nx_s   = SEG_BLANK;
        dp_nx_s    = 1'b1;

        if (cur_r >= 4'd10) begin
            tens_s = 1'b1;
            ones_s = cur_r - 4'd10;
        end else begin
            tens_s = 1'b0;
            ones_s = cur_r;
        end

        // A wrap needs a previous sample to compare against, hence primed_r.
        up_evt_s = bus.count_valid & primed_r & (cur_r == 4'd15) & (bus.count_in == 4'd0);
        dn_evt_s = bus.count_valid & primed_r & (cur_r == 4'd0)  & (bus.count_in == 4'd15);

        if (rc_r == RC_LAST) begin
            rc_nx_s    = 16'd0;
            state_nx_s = ~state_r;
        end else begin
            rc_nx_s    = rc_r + 16'd1;
            state_nx_s = state_r;
        end

        // First cycle of every slot is blanked so the previous digit never ghosts.
        if (rc_r == 16'd0) begin
            an_nx_s  = 2'b11;
            seg_nx_s = SEG_BLANK;
            dp_nx_s  = 1'b1;
        end else begin
            case (state_r)
                ST_ONES: begin
                    an_nx_s  = 2'b10;
                    seg_nx_s = font(ones_s);
                    dp_nx_s  = ~(wrap_up_r | wrap_dn_r);
                end
                ST_TENS: begin
                    an_nx_s  = 2'b01;
                    seg_nx_s = tens_s ? font(4'd1) : SEG_BLANK;
                    dp_nx_s  = 1'b1;
                end
                default: begin
                    an_nx_s  = 2'b11;
                    seg_nx_s = SEG_BLANK;
                    dp_nx_s  = 1'b1;
                end
            endcase
        end
    end

    // State, flags and registered display outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            cur_r     <= 4'd0;
            primed_r  <= 1'b0;
            wrap_up_r <= 1'b0;
            wrap_dn_r <= 1'b0;
            rc_r      <= 16'd0;
            state_r   <= ST_ONES;
            an_r      <= 2'b11;
            seg_r     <= SEG_BLANK;
            dp_r      <= 1'b1;
        end else begin
            if (bus.count_valid) begin
                cur_r    <= bus.count_in;
                primed_r <= 1'b1;
            end else begin
                cur_r    <= cur_r;
                primed_r <= primed_r;
            end
            // A new event beats a simultaneous acknowledge.
            wrap_up_r <= up_evt_s | (wrap_up_r & ~bus.wrap_ack);
            wrap_dn_r <= dn_evt_s | (wrap_dn_r & ~bus.wrap_ack);
            rc_r      <= rc_nx_s;
            state_r   <= state_nx_s;
            an_r      <= an_nx_s;
            seg_r     <= seg_nx_s;
            dp_r      <= dp_nx_s;
        end
    end

    assign bus.an      = an_r;
    assign bus.seg     = seg_r;
    assign bus.dp      = dp_r;
    assign bus.wrap_up = wrap_up_r;
    assign bus.wrap_dn = wrap_dn_r;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with an 8-edge frame (REFRESH_CNT=4):
// edge 0 blank, 1..3 ones digit, 4 blank, 5..7 tens digit.
module tb_count_display_driver;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    count_display_if cdi ();

    count_display_driver #(.REFRESH_CNT(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (cdi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".an"},  7'(cdi.an),      7'b0000011);
        check_eq({tag, ".seg"}, cdi.seg,         7'b1111111);
        check_eq({tag, ".dp"},  7'(cdi.dp),      7'd1);
        check_eq({tag, ".up"},  7'(cdi.wrap_up), 7'd0);
        check_eq({tag, ".dn"},  7'(cdi.wrap_dn), 7'd0);
    endtask

    // One sample (plus optional ack) at frame edge 0, then check all 8 edges.
    task automatic frame(input string tag, input logic [3:0] val, input logic [6:0] s1,
                         input logic [6:0] s10, input logic dp1, input logic up,
                         input logic dn, input logic ack);
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        cdi.count_in    = val;
        cdi.count_valid = 1'b1;
        cdi.wrap_ack    = ack;
        for (int i = 0; i < 8; i++) begin
            tick();
            cdi.count_valid = 1'b0;
            cdi.wrap_ack    = 1'b0;
            exp_an  = (i == 0 || i == 4) ? 2'b11 : ((i < 4) ? 2'b10 : 2'b01);
            exp_seg = (i == 0 || i == 4) ? 7'b1111111 : ((i < 4) ? s1 : s10);
            exp_dp  = (i >= 1 && i <= 3) ? dp1 : 1'b1;
            check_eq($sformatf("%s.an%0d", tag, i),  7'(cdi.an),      7'(exp_an));
            check_eq($sformatf("%s.seg%0d", tag, i), cdi.seg,         exp_seg);
            check_eq($sformatf("%s.dp%0d", tag, i),  7'(cdi.dp),      7'(exp_dp));
            check_eq($sformatf("%s.up%0d", tag, i),  7'(cdi.wrap_up), 7'(up));
            check_eq($sformatf("%s.dn%0d", tag, i),  7'(cdi.wrap_dn), 7'(dn));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr             = 1'b1;
        cdi.count_in    = 4'd0;
        cdi.count_valid = 1'b0;
        cdi.wrap_ack    = 1'b0;

        // Two-cycle reset, then digit 7.
        tick();
        tick();
        check_reset_state("rst");
        clr = 1'b0;
        frame("load7",  4'd7,  7'b0001111, 7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0);
        frame("load12", 4'd12, 7'b0010010, 7'b1001111, 1'b1, 1'b0, 1'b0, 1'b0);

        // 15 then 0 raises wrap_up; ack clears it on the next edge.
        frame("load15", 4'd15, 7'b0100100, 7'b1001111, 1'b1, 1'b0, 1'b0, 1'b0);
        frame("up0",    4'd0,  7'b0000001, 7'b1111111, 1'b0, 1'b1, 1'b0, 1'b0);
        cdi.wrap_ack = 1'b1;
        tick();
        cdi.wrap_ack = 1'b0;
        check_eq("ack.up", 7'(cdi.wrap_up), 7'd0);
        check_eq("ack.dn", 7'(cdi.wrap_dn), 7'd0);
        tick();
        check_eq("ack.dp", 7'(cdi.dp),  7'd1);
        check_eq("ack.an", 7'(cdi.an),  7'b0000010);
        for (int i = 0; i < 6; i++) tick();

        // Unprimed first sample of 15 after reset must not flag a down-wrap.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_reset_state("rst2");
        frame("prime15", 4'd15, 7'b0100100, 7'b1001111, 1'b1, 1'b0, 1'b0, 1'b0);
        frame("wrapup",  4'd0,  7'b0000001, 7'b1111111, 1'b0, 1'b1, 1'b0, 1'b0);
        frame("wrapdn",  4'd15, 7'b0100100, 7'b1001111, 1'b0, 1'b1, 1'b1, 1'b0);

        // Ack coincident with a 15->0 wrap: up set, dn cleared.
        frame("ackset",  4'd0,  7'b0000001, 7'b1111111, 1'b0, 1'b1, 1'b0, 1'b1);

        // Both flags set, cur=9, then clr in the middle of a tens slot.
        frame("dnagain", 4'd15, 7'b0100100, 7'b1001111, 1'b0, 1'b1, 1'b1, 1'b0);
        frame("load9",   4'd9,  7'b0000100, 7'b1111111, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        clr             = 1'b1;
        cdi.count_in    = 4'd5;
        cdi.count_valid = 1'b1;
        cdi.wrap_ack    = 1'b0;
        tick();
        clr             = 1'b0;
        cdi.count_valid = 1'b0;
        check_reset_state("midrst");
        tick();
        check_eq("restart.an0", 7'(cdi.an), 7'b0000011);
        tick();
        check_eq("restart.an1",  7'(cdi.an), 7'b0000010);
        check_eq("restart.seg1", cdi.seg,    7'b0000001);
        check_eq("restart.dp1",  7'(cdi.dp), 7'd1);
        for (int i = 0; i < 6; i++) tick();
        frame("post15", 4'd15, 7'b0100100, 7'b1001111, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
